// File: rtl/id_stage_if.sv
// Decode-stage bus: IF-side inputs, writeback port and ID/EX outputs.
// master drives instruction/control/writeback; slave (id_stage) drives ID/EX.
interface id_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [DW-1:0] Ins;
    logic          InsValid;
    logic          Stall;
    logic          Flush;
    logic          WEn;
    logic [AW-1:0] WAddr;
    logic [DW-1:0] WData;
    logic [DW-1:0] InsOut;
    logic [DW-1:0] Rdata1;
    logic [DW-1:0] Rdata2;
    logic [DW-1:0] Ed32;
    logic [AW-1:0] DstAddr;
    logic          RegWrite;
    logic          ValidOut;

    modport master (
        output Ins, InsValid, Stall, Flush,
        output WEn, WAddr, WData,
        input  InsOut, Rdata1, Rdata2, Ed32,
        input  DstAddr, RegWrite, ValidOut
    );

    modport slave (
        input  Ins, InsValid, Stall, Flush,
        input  WEn, WAddr, WData,
        output InsOut, Rdata1, Rdata2, Ed32,
        output DstAddr, RegWrite, ValidOut
    );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: 32x32 GPR file, field/immediate decode, ID/EX register.
// Ports: CLK, RST (async, active-high), bus (id_stage_if.slave).
// Option: define ID_WB_BYPASS_EN to forward same-edge writebacks into Rdata.
module id_stage #(
    parameter int            NREG = 32,
    parameter int            DW   = 32,
    parameter logic [DW-1:0] NOP  = '0
) (
    input logic        CLK,
    input logic        RST,
    id_stage_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [DW-1:0] gpr [NREG];

    logic [5:0]    op;
    logic [AW-1:0] rs, rt, rd;
    logic [15:0]   imm;
    logic [DW-1:0] sext, zext, uimm;
    logic [DW-1:0] ext;
    logic [AW-1:0] dst;
    logic          wr;
    logic [DW-1:0] rd1, rd2;

    assign op   = bus.Ins[31:26];
    assign rs   = bus.Ins[25:21];
    assign rt   = bus.Ins[20:16];
    assign rd   = bus.Ins[15:11];
    assign imm  = bus.Ins[15:0];
    assign sext = {{(DW-16){imm[15]}}, imm};
    assign zext = {{(DW-16){1'b0}}, imm};
    assign uimm = {imm, {(DW-16){1'b0}}};

    always_comb begin
        ext = '0;
        wr  = 1'b0;
        dst = rt;
        unique case (1'b1)
            op == OP_R: begin
                wr  = 1'b1;
                dst = rd;
            end
            op inside {OP_ADDI, OP_ADDIU,
                       OP_SLTI, OP_SLTIU,
                       OP_LW}: begin
                ext = sext;
                wr  = 1'b1;
            end
            op inside {OP_ANDI, OP_ORI,
                       OP_XORI}: begin
                ext = zext;
                wr  = 1'b1;
            end
            op == OP_LUI: begin
                ext = uimm;
                wr  = 1'b1;
            end
            op == OP_SW: ext = sext;
            default: ;
        endcase
        // $0 is hard-wired, so nothing targeting it is a real write
        if (dst == '0) wr = 1'b0;
    end

    always_comb begin
        rd1 = (rs == '0) ? '0 : gpr[rs];
        rd2 = (rt == '0) ? '0 : gpr[rt];
`ifdef ID_WB_BYPASS_EN
        // write-before-read: same-edge writeback is seen by this decode
        if (bus.WEn && bus.WAddr != '0) begin
            if (bus.WAddr == rs) rd1 = bus.WData;
            if (bus.WAddr == rt) rd2 = bus.WData;
        end
`endif
    end

    // writeback runs regardless of Stall/Flush
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else if (bus.WEn && bus.WAddr != '0) begin
            gpr[bus.WAddr] <= bus.WData;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.InsOut   <= NOP;
            bus.Rdata1   <= '0;
            bus.Rdata2   <= '0;
            bus.Ed32     <= '0;
            bus.DstAddr  <= '0;
            bus.RegWrite <= 1'b0;
            bus.ValidOut <= 1'b0;
        end else if (bus.Flush || (!bus.Stall && !bus.InsValid)) begin
            bus.InsOut   <= NOP;
            bus.Rdata1   <= '0;
            bus.Rdata2   <= '0;
            bus.Ed32     <= '0;
            bus.DstAddr  <= '0;
            bus.RegWrite <= 1'b0;
            bus.ValidOut <= 1'b0;
        end else if (!bus.Stall) begin
            bus.InsOut   <= bus.Ins;
            bus.Rdata1   <= rd1;
            bus.Rdata2   <= rd2;
            bus.Ed32     <= ext;
            bus.DstAddr  <= dst;
            bus.RegWrite <= wr;
            bus.ValidOut <= 1'b1;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus random traffic
// against a behavioural model of the decode stage.
module tb_id_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 CLK = ~CLK;

    id_stage_if bus ();

    id_stage dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // model state
    int unsigned   mgpr [32];
    logic [31:0]   e_ins, e_r1, e_r2, e_ed;
    logic [4:0]    e_dst;
    logic          e_rw, e_v;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ins"}, bus.InsOut, e_ins);
        chk({tag, ".r1"},  bus.Rdata1, e_r1);
        chk({tag, ".r2"},  bus.Rdata2, e_r2);
        chk({tag, ".ed"},  bus.Ed32, e_ed);
        chk({tag, ".dst"}, {27'd0, bus.DstAddr}, {27'd0, e_dst});
        chk({tag, ".rw"},  {31'd0, bus.RegWrite}, {31'd0, e_rw});
        chk({tag, ".v"},   {31'd0, bus.ValidOut}, {31'd0, e_v});
    endtask

    task automatic model_bubble();
        e_ins = 32'h0; e_r1 = 0; e_r2 = 0; e_ed = 0;
        e_dst = 0; e_rw = 0; e_v = 0;
    endtask

    function automatic int unsigned rdreg(input int n);
        int unsigned v;
        v = (n == 0) ? 0 : mgpr[n];
`ifdef ID_WB_BYPASS_EN
        if (bus.WEn && bus.WAddr != 0 && int'(bus.WAddr) == n)
            v = bus.WData;
`endif
        return v;
    endfunction

    // one clock edge: predict, apply, compare
    task automatic tick(input string tag);
        int op, rs, rt, rd, imm;
        op  = int'(bus.Ins >> 26) & 63;
        rs  = int'(bus.Ins >> 21) & 31;
        rt  = int'(bus.Ins >> 16) & 31;
        rd  = int'(bus.Ins >> 11) & 31;
        imm = int'(bus.Ins & 32'hFFFF);
        if (bus.Flush || (!bus.Stall && !bus.InsValid)) begin
            model_bubble();
        end else if (!bus.Stall) begin
            e_ins = bus.Ins;
            e_r1  = rdreg(rs);
            e_r2  = rdreg(rt);
            e_v   = 1;
            e_dst = 5'(rt);
            e_rw  = 1;
            case (op)
                0: begin e_ed = 0; e_dst = 5'(rd); end
                8, 9, 10, 11, 35:
                    e_ed = (imm >= 32768) ? imm - 65536 : imm;
                12, 13, 14: e_ed = imm;
                15: e_ed = imm * 65536;
                43: begin e_ed = (imm >= 32768) ? imm - 65536 : imm; e_rw = 0; end
                default: begin e_ed = 0; e_rw = 0; end
            endcase
            if (e_dst == 0) e_rw = 0;
        end
        if (bus.WEn && bus.WAddr != 0) mgpr[bus.WAddr] = bus.WData;
        @(posedge CLK);
        #1;
        chk_all(tag);
    endtask

    task automatic idle();
        bus.Ins = 0; bus.InsValid = 0; bus.Stall = 0;
        bus.Flush = 0; bus.WEn = 0; bus.WAddr = 0; bus.WData = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.WEn = 1; bus.WAddr = 5'(a); bus.WData = d;
    endtask

    logic [31:0] h_ins, h_r1, h_ed;
    int          ops [12] = '{0, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 63};

    initial begin
        idle();
        for (int i = 0; i < 32; i++) mgpr[i] = 0;
        model_bubble();
        #12;
        chk_all("reset");
        RST = 0;
        @(negedge CLK);

        // T2: writeback then addi $9,$8,-1
        wr(8, 32'h1234);
        tick("t2wb");
        idle();
        bus.Ins = 32'h2109FFFF; bus.InsValid = 1;
        tick("t2");
        chk("t2.r1c", bus.Rdata1, 32'h1234);
        chk("t2.edc", bus.Ed32, 32'hFFFFFFFF);
        chk("t2.dstc", {27'd0, bus.DstAddr}, 32'd9);
        chk("t2.rwc", {31'd0, bus.RegWrite}, 32'd1);

        // T3: same-edge hazard on $3
        idle();
        wr(3, 32'h11);
        tick("t3pre");
        bus.Ins = 32'h00602020; bus.InsValid = 1;
        wr(3, 32'hAA);
        tick("t3");
`ifdef ID_WB_BYPASS_EN
        chk("t3.r1c", bus.Rdata1, 32'hAA);
`else
        chk("t3.r1c", bus.Rdata1, 32'h11);
`endif

        // T4: $0 stays zero, zero/upper extension
        idle();
        wr(0, 32'h5);
        tick("t4wb");
        idle();
        bus.Ins = 32'h34008000; bus.InsValid = 1;
        tick("t4ori");
        chk("t4.r1c", bus.Rdata1, 32'h0);
        chk("t4.edc", bus.Ed32, 32'h00008000);
        chk("t4.rwc", {31'd0, bus.RegWrite}, 32'd0);
        bus.Ins = 32'h3C018000;
        tick("t4lui");
        chk("t4.luic", bus.Ed32, 32'h80000000);

        // T5: stall holds, writeback into a held source is not picked up
        bus.Ins = 32'h21090004;
        tick("t5load");
        h_ins = bus.InsOut; h_r1 = bus.Rdata1; h_ed = bus.Ed32;
        bus.Stall = 1;
        wr(8, 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            bus.Ins = $urandom;
            tick("t5stall");
            chk("t5.hins", bus.InsOut, h_ins);
            chk("t5.hr1", bus.Rdata1, h_r1);
            chk("t5.hed", bus.Ed32, h_ed);
        end
        bus.WEn = 0;
        bus.Flush = 1;
        tick("t5flush");
        chk("t5.fv", {31'd0, bus.ValidOut}, 32'd0);
        chk("t5.fins", bus.InsOut, 32'd0);
        chk("t5.frw", {31'd0, bus.RegWrite}, 32'd0);

        // T6: unknown opcode
        idle();
        bus.Ins = {6'h3F, 26'($urandom)}; bus.InsValid = 1;
        tick("t6");
        chk("t6.edc", bus.Ed32, 32'd0);
        chk("t6.rwc", {31'd0, bus.RegWrite}, 32'd0);
        chk("t6.vc", {31'd0, bus.ValidOut}, 32'd1);

        // T1: async reset while stalled, then $5 reads zero
        idle();
        wr(5, 32'h55);
        bus.Ins = 32'h00A03020; bus.InsValid = 1;
        tick("t1pre");
        bus.WEn = 0;
        bus.Stall = 1;
        #2;
        RST = 1;
        for (int i = 0; i < 32; i++) mgpr[i] = 0;
        model_bubble();
        #1;
        chk_all("t1async");
        #2;
        RST = 0;
        bus.Stall = 0;
        tick("t1read");
        chk("t1.r1c", bus.Rdata1, 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bus.Ins = {6'(ops[$urandom_range(0, 11)]), 26'($urandom)};
            bus.InsValid = ($urandom_range(0, 9) < 8);
            bus.Stall = ($urandom_range(0, 3) == 0);
            bus.Flush = ($urandom_range(0, 15) == 0);
            bus.WEn = $urandom_range(0, 1) == 1;
            bus.WAddr = 5'($urandom);
            bus.WData = $urandom;
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
